// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared constants for the VRAM read-port arbiter
package vram_arb_pkg;

    localparam int ADR_W_DEF = 23;

    // Owner tag stored per outstanding read
    localparam logic OWN_DSP = 1'b0;
    localparam logic OWN_SND = 1'b1;

endpackage

// File: rtl/vram_rd_arb_if.sv
// rtl/vram_rd_arb_if.sv - requester and VRAM-interface handshake bundle for vram_rd_arb
interface vram_rd_arb_if
    import vram_arb_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF
);

    logic             DSP_VRAMREQ;
    logic [ADR_W-1:0] DSP_VRAMADR;
    logic             DSP_VRAMACK;
    logic             DSP_RDATAVLD;
    logic             SND_VRAMREQ;
    logic [ADR_W-1:0] SND_VRAMADR;
    logic             VIF_SNDACK;
    logic             VIF_SNDRDATAVLD;
    logic             VIF_REQ;
    logic [ADR_W-1:0] VIF_ADR;
    logic             VIF_ACK;
    logic             VIF_RDATAVLD;

    // master: the arbiter itself; slave: requesters plus VRAM interface
    modport master (
        input  DSP_VRAMREQ, DSP_VRAMADR, SND_VRAMREQ, SND_VRAMADR, VIF_ACK, VIF_RDATAVLD,
        output DSP_VRAMACK, DSP_RDATAVLD, VIF_SNDACK, VIF_SNDRDATAVLD, VIF_REQ, VIF_ADR
    );

    modport slave (
        output DSP_VRAMREQ, DSP_VRAMADR, SND_VRAMREQ, SND_VRAMADR, VIF_ACK, VIF_RDATAVLD,
        input  DSP_VRAMACK, DSP_RDATAVLD, VIF_SNDACK, VIF_SNDRDATAVLD, VIF_REQ, VIF_ADR
    );

endinterface

// File: rtl/vram_tag_fifo.sv
// rtl/vram_tag_fifo.sv - 1-bit owner-tag FIFO tracking outstanding VRAM reads in issue order
module vram_tag_fifo
    import vram_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          push,
    input  logic          push_owner,
    input  logic          pop,
    output logic          head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // DEPTH is a power of two, so natural pointer overflow is the wrap
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_owner;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_rd_arb.sv
// rtl/vram_rd_arb.sv - display/sound arbiter for the shared VRAM read port with in-order return routing
module vram_rd_arb
    import vram_arb_pkg::*;
#(
    parameter int ADR_W      = ADR_W_DEF,
    parameter int TAG_DEPTH  = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic          CLK,
    input  logic          RST_X,
    vram_rd_arb_if.master bus,
    output logic          ARB_ERR,
    output logic          ARB_BUSY
);

    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic             en;
    logic             force_snd;
    logic [SW-1:0]    starve_cnt;
    logic [ADR_W-1:0] dsp_adr;
    logic [ADR_W-1:0] snd_adr;
    logic             sel_snd;
    logic             sel_dsp;
    logic             vif_req;
    logic             push;
    logic             pop;
    logic             snd_loss;
    logic             tag_head;
    logic [CW-1:0]    tag_count;
    logic             tag_full;
    logic             tag_empty;

    assign dsp_adr = bus.DSP_VRAMADR;
    assign snd_adr = bus.SND_VRAMADR;

    // en holds every output low through reset and for the release cycle
    assign sel_snd = bus.SND_VRAMREQ && (!bus.DSP_VRAMREQ || force_snd);
    assign sel_dsp = bus.DSP_VRAMREQ && !sel_snd;
    assign vif_req = en && (bus.DSP_VRAMREQ || bus.SND_VRAMREQ) && !tag_full;
    assign push    = vif_req && bus.VIF_ACK;
    assign pop     = en && bus.VIF_RDATAVLD && !tag_empty;

    assign bus.VIF_REQ         = vif_req;
    assign bus.VIF_ADR         = !en ? '0 : (sel_snd ? snd_adr : dsp_adr);
    assign bus.DSP_VRAMACK     = push && sel_dsp;
    assign bus.VIF_SNDACK      = push && sel_snd;
    assign bus.DSP_RDATAVLD    = pop && (tag_head == OWN_DSP);
    assign bus.VIF_SNDRDATAVLD = pop && (tag_head == OWN_SND);

    assign ARB_BUSY = (tag_count != '0);

    // A loss is only display winning over sound; VIF stalls with sound selected never count
    assign snd_loss = en && bus.SND_VRAMREQ && bus.DSP_VRAMREQ && !sel_snd;

    vram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .push       (push),
        .push_owner (sel_snd ? OWN_SND : OWN_DSP),
        .pop        (pop),
        .head       (tag_head),
        .count      (tag_count),
        .full       (tag_full),
        .empty      (tag_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            en         <= 1'b0;
            force_snd  <= 1'b0;
            starve_cnt <= '0;
            ARB_ERR    <= 1'b0;
        end else begin
            en <= 1'b1;
            if (en && bus.VIF_RDATAVLD && tag_empty) begin
                ARB_ERR <= 1'b1;
            end
            if (bus.VIF_SNDACK || !bus.SND_VRAMREQ) begin
                starve_cnt <= '0;
                force_snd  <= 1'b0;
            end else if (snd_loss && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
                if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                    force_snd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_rd_arb.sv
// tb/tb_vram_rd_arb.sv - self-checking bench for vram_rd_arb
module tb_vram_rd_arb;
    import vram_arb_pkg::*;

    localparam int AW = 23;

    logic CLK;
    logic RST_X;
    logic ARB_ERR;
    logic ARB_BUSY;

    int checks;
    int errors;

    vram_rd_arb_if #(.ADR_W(AW)) bus ();

    vram_rd_arb #(
        .ADR_W      (AW),
        .TAG_DEPTH  (8),
        .STARVE_MAX (16)
    ) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .bus      (bus),
        .ARB_ERR  (ARB_ERR),
        .ARB_BUSY (ARB_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // exp bits: {VIF_REQ, DSP_VRAMACK, VIF_SNDACK, DSP_RDATAVLD, VIF_SNDRDATAVLD, ARB_BUSY, ARB_ERR}
    typedef struct {
        logic          dreq;
        logic [AW-1:0] dadr;
        logic          sreq;
        logic [AW-1:0] sadr;
        logic          ack;
        logic          vld;
        logic [AW-1:0] eadr;
        logic [6:0]    exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic dreq, input int dadr, input logic sreq, input int sadr,
                                input logic ack, input logic vld, input int eadr, input logic [6:0] exp);
        vec_t v;
        v.dreq = dreq;
        v.dadr = AW'(dadr);
        v.sreq = sreq;
        v.sadr = AW'(sadr);
        v.ack  = ack;
        v.vld  = vld;
        v.eadr = AW'(eadr);
        v.exp  = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.VIF_REQ, bus.DSP_VRAMACK, bus.VIF_SNDACK, bus.DSP_RDATAVLD,
                bus.VIF_SNDRDATAVLD, ARB_BUSY, ARB_ERR};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dreq, input logic [AW-1:0] dadr, input logic sreq,
                         input logic [AW-1:0] sadr, input logic ack, input logic vld);
        bus.DSP_VRAMREQ  = dreq;
        bus.DSP_VRAMADR  = dadr;
        bus.SND_VRAMREQ  = sreq;
        bus.SND_VRAMADR  = sadr;
        bus.VIF_ACK      = ack;
        bus.VIF_RDATAVLD = vld;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        RST_X = 1'b0;
        tick();
        tick();
        RST_X = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset hold with both requests and ack asserted
        RST_X = 1'b0;
        drive(1'b1, AW'('h10), 1'b1, AW'('h20), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check($sformatf("rst_hold%0d", i), 32'(outs()), 32'h0);
        end
        RST_X = 1'b1;
        #1;
        check("rst_release_cycle", 32'(outs()), 32'h0);
        tick();
        #1;
        check("rst_first_active", 32'(outs()), 32'(7'b1100000));

        // Fixed display priority with starvation forcing one sound grant
        reset_dut();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, AW'('h100), 1'b1, AW'('h200), 1'b1, (i > 0));
            #1;
            if (i == 16)
                check($sformatf("prio_c%0d", i + 1), {bus.DSP_VRAMACK, bus.VIF_SNDACK, 7'b0, bus.VIF_ADR},
                      {1'b0, 1'b1, 7'b0, AW'('h200)});
            else
                check($sformatf("prio_c%0d", i + 1), {bus.DSP_VRAMACK, bus.VIF_SNDACK, 7'b0, bus.VIF_ADR},
                      {1'b1, 1'b0, 7'b0, AW'('h100)});
            tick();
        end

        // Tag FIFO full: request drops, and resumes only the cycle after a pop
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, AW'('h300 + i), 1'b1, 1'b0);
            #1;
            check($sformatf("full_fill%0d", i), {bus.VIF_REQ, bus.VIF_SNDACK}, 2'b11);
            tick();
        end
        #1;
        check("full_stall", {ARB_BUSY, bus.VIF_REQ, bus.VIF_SNDACK}, 3'b100);
        bus.VIF_RDATAVLD = 1'b1;
        #1;
        check("full_pop_same_cycle", {bus.VIF_REQ, bus.VIF_SNDACK, bus.VIF_SNDRDATAVLD}, 3'b001);
        tick();
        bus.VIF_RDATAVLD = 1'b0;
        #1;
        check("full_resume", {bus.VIF_REQ, bus.VIF_SNDACK}, 2'b11);
        tick();

        // Routing, push/pop in one cycle, ARB_ERR on orphan valid
        vecs.push_back(mk(1, 'h10, 0, 0,    1, 0, 'h10, 7'b1100000));
        vecs.push_back(mk(0, 0,    1, 'h20, 1, 0, 'h20, 7'b1010010));
        vecs.push_back(mk(0, 0,    1, 'h21, 1, 0, 'h21, 7'b1010010));
        vecs.push_back(mk(1, 'h11, 0, 0,    1, 0, 'h11, 7'b1100010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0001010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,    7'b0000010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0000110));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0000110));
        vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,    7'b0000010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0001010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,    7'b0000000));
        vecs.push_back(mk(0, 0,    1, 'h30, 1, 0, 'h30, 7'b1010000));
        vecs.push_back(mk(1, 'h40, 0, 0,    1, 0, 'h40, 7'b1100010));
        vecs.push_back(mk(1, 'h41, 0, 0,    1, 0, 'h41, 7'b1100010));
        vecs.push_back(mk(1, 'h42, 0, 0,    1, 1, 'h42, 7'b1100110));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0001010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0001010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0001010));
        vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,    7'b0000000));
        vecs.push_back(mk(0, 0,    0, 0,    0, 1, 0,    7'b0000000));
        vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,    7'b0000001));
        vecs.push_back(mk(1, 'h50, 0, 0,    0, 0, 'h50, 7'b1000001));
        vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,    7'b0000001));

        reset_dut();
        foreach (vecs[i]) begin
            drive(vecs[i].dreq, vecs[i].dadr, vecs[i].sreq, vecs[i].sadr, vecs[i].ack, vecs[i].vld);
            #1;
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            check($sformatf("vec%0d_adr", i), 32'(bus.VIF_ADR), 32'(vecs[i].eadr));
            tick();
        end

        // Sticky error clears only through reset
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        check("err_sticky", 32'(ARB_ERR), 32'h1);
        RST_X = 1'b0;
        tick();
        check("err_cleared", 32'(ARB_ERR), 32'h0);
        RST_X = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_rd_arb.md
Name: vram_rd_arb

Overview:
- Shares the single VRAM read port (VIF) between two requesters: the display fetch controller and the sound fetch controller.
- The display side has fixed priority. The sound side has a starvation guard so audio buffers never underrun.
- Tracks outstanding reads in an in-order owner-tag FIFO and routes each VIF_RDATAVLD back to the requester that issued it.
- Sits between the requester controllers and the VRAM interface block.

Parameters:
ADR_W, 23, VRAM word address width
TAG_DEPTH, 8, max outstanding reads (power of 2, >=2)
STARVE_MAX, 16, cycles a pending sound request may lose arbitration before it is forced to win

Ports:
CLK  in  1  system clock
RST_X  in  1  reset
DSP_VRAMREQ  in  1  display read request, held until acked
DSP_VRAMADR  in  ADR_W  display read address
DSP_VRAMACK  out  1  display request accepted this cycle
DSP_RDATAVLD  out  1  VIF_RDATA belongs to display this cycle
SND_VRAMREQ  in  1  sound read request, held until acked
SND_VRAMADR  in  ADR_W  sound read address
VIF_SNDACK  out  1  sound request accepted this cycle
VIF_SNDRDATAVLD  out  1  VIF_RDATA belongs to sound this cycle
VIF_REQ  out  1  request to VRAM interface
VIF_ADR  out  ADR_W  address to VRAM interface
VIF_ACK  in  1  VRAM interface accepts VIF_REQ this cycle
VIF_RDATAVLD  in  1  read data valid, returned in issue order
ARB_ERR  out  1  sticky: data valid arrived with no outstanding tag
ARB_BUSY  out  1  one or more reads outstanding

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST_X is synchronous and active-low.
- Reset values: all registers are cleared; tag count = 0, starvation counter = 0, force flag = 0, ARB_ERR = 0.
  - All outputs derive from these registers, so every output is 0 during and after reset.
- Reset mid-operation: the tag FIFO is discarded. Any VIF_RDATAVLD arriving after reset with count = 0 sets ARB_ERR. The VIF is reset in the same domain, so this does not occur in normal operation.
- Grant selection (combinational, zero latency):
  - sel_snd = SND_VRAMREQ && (!DSP_VRAMREQ || force).
  - sel_dsp = DSP_VRAMREQ && !sel_snd.
- VIF_REQ = (DSP_VRAMREQ || SND_VRAMREQ) && (count != TAG_DEPTH).
- VIF_ADR = SND_VRAMADR when sel_snd, else DSP_VRAMADR.
- Acks: DSP_VRAMACK = VIF_REQ && VIF_ACK && sel_dsp. VIF_SNDACK = VIF_REQ && VIF_ACK && sel_snd. Exactly one of the two is high on any accepted cycle.
- Full condition: when count == TAG_DEPTH, VIF_REQ is low even if a pop occurs the same cycle. The request resumes the following cycle.
- Tag FIFO: entries are 1 bit (1 = sound); width is clog2(TAG_DEPTH)+1 for count.
  - Push the owner bit on VIF_REQ && VIF_ACK.
  - Pop on VIF_RDATAVLD when count != 0.
  - Simultaneous push and pop: count unchanged, pointers both advance.
  - Pointers wrap modulo TAG_DEPTH.
- Data routing (combinational from head entry):
  - VIF_SNDRDATAVLD = VIF_RDATAVLD && count != 0 && head == 1.
  - DSP_RDATAVLD = VIF_RDATAVLD && count != 0 && head == 0.
  - A valid with count == 0 is dropped and sets ARB_ERR; ARB_ERR clears only on reset.
- Starvation guard (registered):
  - Counter increments each cycle SND_VRAMREQ is high and VIF_SNDACK is low, but only while DSP_VRAMREQ is high. It saturates at STARVE_MAX.
  - force sets when the counter reaches STARVE_MAX - 1 and increments. Force is therefore effective the cycle after the STARVE_MAX-th lost cycle.
  - Counter and force both clear on VIF_SNDACK, or when SND_VRAMREQ drops.
  - Cycles stalled by the full condition or VIF_ACK = 0 with sound selected do not count as losses.
- ARB_BUSY = (count != 0).
- There is no FSM beyond the force flag. Arbitration state is the force bit plus the counter.

Decomposition:
- Shared package (vram_arb_pkg): ADR_W default, owner encoding constants OWN_DSP = 0 and OWN_SND = 1.
- Sub-module vram_tag_fifo: 1-bit-wide, TAG_DEPTH-deep sync FIFO with push, pop, head, count, full and empty.
  - Pop is gated by !empty internally.
  - Push is gated by !full internally; the arbiter itself never pushes when full.

Test Plan:
- Reset: hold RST_X = 0 for 3 cycles with both requests high and VIF_ACK = 1 -> VIF_REQ, both acks and ARB_ERR stay 0 until the first cycle after release.
- Priority: both requests high, VIF_ACK = 1 always, STARVE_MAX = 16 -> 16 DSP_VRAMACKs, then one VIF_SNDACK on cycle 17, then the display resumes.
- Routing: issue D, S, S, D (addresses 0x10, 0x20, 0x21, 0x11); return 4 valids with a gap -> DSP_RDATAVLD, VIF_SNDRDATAVLD, VIF_SNDRDATAVLD, DSP_RDATAVLD in that order; ARB_BUSY falls after the 4th.
- Full: TAG_DEPTH = 8, no returns, sound requesting -> 8 acks, then VIF_REQ = 0. One VIF_RDATAVLD then gives VIF_REQ = 1 again the next cycle, not the same cycle.
- Push and pop same cycle: count = 3, ack and valid together -> count stays 3 and the routed owner is the old head.
- Error: VIF_RDATAVLD = 1 with count = 0 -> no routed valid, ARB_ERR = 1 and held; it clears only after RST_X = 0.
